// File: rtl/ehl_cg_pkg.sv
// Shared definitions for the clock-gate controller: FSM state encodings and timer width.
package ehl_cg_pkg;

    localparam int TIMER_W = 8;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_WAKE = 2'd1,
        ST_ON   = 2'd2,
        ST_IDLE = 2'd3
    } cg_state_e;

endpackage

// File: rtl/ehl_cg_timer.sv
// 8-bit loadable down counter shared by the wake-settle and idle-hysteresis phases.
module ehl_cg_timer
    import ehl_cg_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_val,
    input  logic               dec,
    output logic               zero
);

    logic [TIMER_W-1:0] cnt;

    // Load wins over decrement; the count parks at zero instead of wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/ehl_clk_gate_ctrl.sv
// Shared clock-branch gating controller with wake settle and idle hysteresis.
// Optional OFF->WAKE counter on wake_cnt_o when EHL_CLK_GATE_CTRL_STATS_EN is defined.
module ehl_clk_gate_ctrl
    import ehl_cg_pkg::*;
#(
    parameter int TECHNOLOGY  = 0,
    parameter int N_REQ       = 4,
    parameter int WAKE_CYCLES = 2,
    parameter int IDLE_CYCLES = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    input  logic             force_on,
    output logic [N_REQ-1:0] ack,
    output logic             gate_en_o,
    output logic [1:0]       state_o,
    output logic             busy_o
`ifdef EHL_CLK_GATE_CTRL_STATS_EN
    ,
    output logic [15:0]      wake_cnt_o
`endif
);

    generate
        if ((TECHNOLOGY < 0) || (N_REQ < 1) || (N_REQ > 16) ||
            (WAKE_CYCLES < 1) || (WAKE_CYCLES > 255) ||
            (IDLE_CYCLES < 1) || (IDLE_CYCLES > 255)) begin : g_bad_param
            $error("ehl_clk_gate_ctrl: parameter out of range");
        end
    endgenerate

    localparam logic [TIMER_W-1:0] WAKE_LOAD = TIMER_W'(WAKE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] IDLE_LOAD = TIMER_W'(IDLE_CYCLES - 1);

    cg_state_e          state_q;
    cg_state_e          state_nxt;
    logic               any_req;
    logic               tmr_load;
    logic [TIMER_W-1:0] tmr_val;
    logic               tmr_dec;
    logic               tmr_zero;

    assign any_req = (|req) | force_on;

    ehl_cg_timer u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    // Next state and timer control; every state entry reloads the timer.
    always_comb begin
        state_nxt = state_q;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        tmr_dec   = 1'b0;
        case (state_q)
            ST_OFF: begin
                if (any_req) begin
                    state_nxt = ST_WAKE;
                    tmr_load  = 1'b1;
                    tmr_val   = WAKE_LOAD;
                end
            end
            ST_WAKE: begin
                if (tmr_zero) begin
                    state_nxt = ST_ON;
                    tmr_load  = 1'b1;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_ON: begin
                if (!any_req) begin
                    state_nxt = ST_IDLE;
                    tmr_load  = 1'b1;
                    tmr_val   = IDLE_LOAD;
                end
            end
            ST_IDLE: begin
                // A request on the expiry edge keeps the clock running.
                if (any_req) begin
                    state_nxt = ST_ON;
                    tmr_load  = 1'b1;
                end else if (tmr_zero) begin
                    state_nxt = ST_OFF;
                    tmr_load  = 1'b1;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_OFF;
                tmr_load  = 1'b1;
            end
        endcase
    end

    // Outputs are registered from the next state so they align with state_q.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_OFF;
            gate_en_o <= 1'b0;
            busy_o    <= 1'b0;
            ack       <= '0;
        end else begin
            state_q   <= state_nxt;
            gate_en_o <= (state_nxt != ST_OFF);
            busy_o    <= (state_nxt != ST_OFF);
            ack       <= (state_nxt == ST_ON) ? req : '0;
        end
    end

    assign state_o = state_q;

`ifdef EHL_CLK_GATE_CTRL_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            wake_cnt_o <= '0;
        end else if ((state_q == ST_OFF) && (state_nxt == ST_WAKE) &&
                     (wake_cnt_o != 16'hFFFF)) begin
            wake_cnt_o <= wake_cnt_o + 16'd1;
        end
    end
`endif

endmodule
